uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one byte-wide UART transmitter between `N_REQ` message sources. Each source streams a message as bytes with valid/ready/last. The arbiter locks the grant for a whole message, feeds bytes to the transmitter with a start/busy handshake, and then rotates priority. It sits between the message generators (string ROM readers, status reporters) and the `tx_uart` instance on the board's 50 MHz clock.

---
 rtl/uart_tx_arbiter_pkg.sv | 19 +
 rtl/uart_tx_arbiter_rr_pick.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   - CLK_HZ       : board clock frequency
//   - STALL_100MS  : cycle count of a 100 ms stall window at CLK_HZ
//   - state_e      : sequencer state encoding (3 bits)
package uart_tx_arbiter_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int STALL_100MS = CLK_HZ / 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_FETCH = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_NEXT  = 3'd5
  } state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req        : request vector, one bit per requester
//   last_owner : index of the requester served most recently
//   win_onehot : one-hot winner (all-zero when no request)
//   win_idx    : binary index of the winner
//   win_any    : at least one request present
// The search starts at last_owner+1 (mod N_REQ); the first set bit wins.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_owner,
  output logic [N_REQ-1:0] win_onehot,
  output logic [IW-1:0]    win_idx,
  output logic             win_any
);

  logic [IW-1:0] idx;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    win_onehot = '0;
    win_idx    = '0;
    win_any    = 1'b0;
    idx        = last_owner;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
      if (!win_any && req[idx]) begin
        win_any         = 1'b1;
        win_onehot[idx] = 1'b1;
        win_idx         = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one byte-wide UART transmitter between N_REQ
// message sources. The grant is locked for a whole message (until a byte
// flagged last, or a mid-message stall timeout), then priority rotates.
//   clk, rst_n  : system clock, synchronous active-low reset
//   req_valid   : per-requester byte available
//   req_data    : per-requester byte, requester i on [8i+7:8i]
//   req_last    : offered byte is the final byte of its message
//   req_ready   : one-cycle accept pulse to the granted requester
//   grant       : one-hot owner of the transmitter, zero when free
//   tx_data     : byte presented to the UART, held until busy falls
//   tx_start    : level request to the UART, held until busy is seen
//   tx_busy     : UART busy (asynchronous, synchronised here)
//   msg_abort   : one-cycle pulse when a stalled message is cut off
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int STALL_CYCLES = STALL_100MS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     grant,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 msg_abort
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(STALL_CYCLES);
  localparam logic [CW-1:0] STALL_LAST = CW'(STALL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] pend_q;        // winner captured in IDLE, granted next
  logic [N_REQ-1:0] grant_q;
  logic [IW-1:0]    owner_q;       // binary index of the current owner
  logic [IW-1:0]    last_owner_q;
  logic [7:0]       tx_data_q;
  logic             last_flag_q;
  logic             armed_q;       // stall timer active (after first byte)
  logic [CW-1:0]    stall_cnt_q;
  logic             busy_s1_q, busy_s2_q;

  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  logic             g_valid;
  logic             g_last;
  logic [7:0]       g_data;
  logic             stall_hit;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (req_valid),
    .last_owner (last_owner_q),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .win_any    (pick_any)
  );

  // Signals of the currently granted requester.
  assign g_valid = req_valid[owner_q];
  assign g_last  = req_last[owner_q];
  assign g_data  = req_data[{owner_q, 3'b000} +: 8];

  // Timeout fires on the cycle the counter sits at its last value with the
  // owner still silent, i.e. the STALL_CYCLES-th idle FETCH cycle.
  assign stall_hit = armed_q && !g_valid && (stall_cnt_q == STALL_LAST);

  // Two-flop synchroniser for the UART busy flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    if (!rst_n) begin
      busy_s1_q <= 1'b0;
      busy_s2_q <= 1'b0;
    end else begin
      busy_s1_q <= tx_busy;
      busy_s2_q <= busy_s1_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (pick_any) state_d = ST_GRANT;
      ST_GRANT: state_d = ST_FETCH;
      ST_FETCH: begin
        if (g_valid)        state_d = ST_START;
        else if (stall_hit) state_d = ST_IDLE;
      end
      ST_START: if (busy_s2_q)  state_d = ST_WAIT;
      ST_WAIT:  if (!busy_s2_q) state_d = ST_NEXT;
      ST_NEXT:  state_d = last_flag_q ? ST_IDLE : ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath: owner bookkeeping, byte latch and stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q       <= '0;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IW'(N_REQ - 1);
      tx_data_q    <= 8'h00;
      last_flag_q  <= 1'b0;
      armed_q      <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          armed_q     <= 1'b0;
          stall_cnt_q <= '0;
          if (pick_any) begin
            pend_q  <= pick_onehot;
            owner_q <= pick_idx;
          end
        end
        ST_GRANT: grant_q <= pend_q;
        ST_FETCH: begin
          if (g_valid) begin
            tx_data_q   <= g_data;
            last_flag_q <= g_last;
            stall_cnt_q <= '0;
          end else if (stall_hit) begin
            // Partial message ends here; nothing already sent is lost.
            grant_q      <= '0;
            last_owner_q <= owner_q;
            armed_q      <= 1'b0;
            stall_cnt_q  <= '0;
          end else if (armed_q && stall_cnt_q != STALL_LAST) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
          end
        end
        ST_NEXT: begin
          if (last_flag_q) begin
            grant_q      <= '0;
            last_owner_q <= owner_q;
            armed_q      <= 1'b0;
          end else begin
            armed_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; reset forces IDLE so all pulses drop at once.
  always_comb begin
    req_ready = '0;
    tx_start  = 1'b0;
    msg_abort = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (g_valid) req_ready = grant_q;
        msg_abort = stall_hit;
      end
      ST_START: tx_start = 1'b1;
      default: ;
    endcase
  end

  assign grant   = grant_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte sources, a UART model
// (3-cycle start latency, 20-cycle busy) and an expected-byte scoreboard.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic           msg_abort;

  uart_tx_arbiter #(.N_REQ(N), .STALL_CYCLES(100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .msg_abort (msg_abort)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte sources: entry = {last, data}; head advances on a seen req_ready.
  logic [8:0] src_mem [N][16];
  int         src_head [N];
  int         src_tail [N];
  int         rdy_cnt  [N];
  logic [N-1:0] rdy;

  task automatic push_src(input int i, input logic [7:0] d, input logic last);
    src_mem[i][src_tail[i]] = {last, d};
    src_tail[i]++;
  endtask

  // Scoreboard of bytes the UART must receive, with their owner.
  typedef struct packed {
    logic [1:0] owner;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input int i, input logic [7:0] d);
    exp_t e;
    e.owner = 2'(i);
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic last);
    push_src(i, d, last);
    push_exp(i, d);
  endtask

  // Source driver.
  initial begin
    for (int i = 0; i < N; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
      rdy_cnt[i]  = 0;
    end
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      rdy = req_ready;
      for (int i = 0; i < N; i++) begin
        if (rdy[i] === 1'b1) begin
          check("ready_to_owner", 32'(grant[i]), 1);
          rdy_cnt[i]++;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rdy[i] === 1'b1 && src_head[i] < src_tail[i]) src_head[i]++;
        req_valid[i]        = (src_head[i] < src_tail[i]);
        req_data[8*i +: 8]  = src_mem[i][src_head[i]][7:0];
        req_last[i]         = src_mem[i][src_head[i]][8];
      end
    end
  end

  // UART model.
  logic uart_en = 1'b1;
  int   bytes_sent = 0;
  initial begin
    logic [7:0] cap;
    exp_t       e;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_en && tx_start === 1'b1) begin
        check("sb_has_entry", 32'(exp_q.size() != 0), 1);
        cap = tx_data;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_tx_data", tx_data, e.data);
          check("sb_owner", grant, 4'b0001 << e.owner);
        end
        repeat (3) @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (20) @(posedge clk);
        #1 tx_busy = 1'b0;
        check("tx_data_stable", tx_data, cap);
        bytes_sent++;
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input logic [N-1:0] val, input int budget, input string tag);
    int n = 0;
    while (grant !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, grant, val);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(grant === '0 && exp_q.size() == 0 && tx_busy === 1'b0) && n < budget);
    check(tag, grant, 0);
    check({tag, "_sb"}, exp_q.size(), 0);
  endtask

  task automatic wait_sig(input string which, input logic val, input int budget);
    int n = 0;
    logic s;
    s = (which == "busy") ? tx_busy : tx_start;
    while (s !== val && n < budget) begin
      @(negedge clk);
      n++;
      s = (which == "busy") ? tx_busy : tx_start;
    end
    check({"wait_", which}, 32'(s), 32'(val));
  endtask

  initial begin
    int c;
    int b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_ready", req_ready, 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_abort", 32'(msg_abort), 0);
    check("rst_tx_data", tx_data, 0);
    rst_n = 1'b1;

    // "Hi" from requester 0, with request-to-grant latency.
    @(negedge clk);
    send(0, 8'h48, 1'b0);
    send(0, 8'h69, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("lat_grant_early", grant, 0);
    @(negedge clk);
    check("lat_grant", grant, 4'b0001);
    check("lat_ready", req_ready, 4'b0001);
    @(negedge clk);
    check("lat_tx_start", 32'(tx_start), 1);
    check("lat_ready_pulse", req_ready, 0);
    wait_drain(200, "hi_done");
    check("hi_ready_cnt", rdy_cnt[0], 2);
    check("hi_bytes", bytes_sent, 2);

    // Simultaneous single-byte messages, twice: order 0,1,2 both times.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      send(0, 8'hA0 + 8'(r), 1'b1);
      send(1, 8'hB0 + 8'(r), 1'b1);
      send(2, 8'hC0 + 8'(r), 1'b1);
      wait_grant(4'b0001, 10, "rr_first");
      wait_drain(400, "rr_done");
    end

    // Requester 1 three bytes; requester 0 arrives mid-message.
    @(negedge clk);
    b0 = bytes_sent;
    send(1, 8'h11, 1'b0);
    send(1, 8'h12, 1'b0);
    send(1, 8'h13, 1'b1);
    wait_grant(4'b0010, 10, "lock_r1");
    c = 0;
    while (bytes_sent < b0 + 1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("lock_first_byte", bytes_sent, b0 + 1);
    send(0, 8'h01, 1'b1);
    wait_drain(400, "lock_done");

    // Stall: requester 2 sends one non-last byte then goes silent.
    @(negedge clk);
    send(2, 8'h5A, 1'b0);
    wait_grant(4'b0100, 10, "stall_grant");
    send(3, 8'hC3, 1'b1);
    wait_sig("busy", 1'b1, 60);
    wait_sig("busy", 1'b0, 60);
    c = 1;
    while (msg_abort !== 1'b1 && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("abort_delay", c, 104);
    check("abort_grant_held", grant, 4'b0100);
    @(negedge clk);
    check("abort_one_cycle", 32'(msg_abort), 0);
    check("abort_grant_clr", grant, 0);
    wait_grant(4'b1000, 10, "abort_next_r3");
    wait_drain(200, "abort_done");

    // Reset while in START (UART not answering).
    uart_en = 1'b0;
    push_src(1, 8'h77, 1'b1);
    wait_sig("start", 1'b1, 20);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_tx_start", 32'(tx_start), 0);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_tx_data", tx_data, 0);
    uart_en = 1'b1;
    send(2, 8'h22, 1'b1);
    send(3, 8'h33, 1'b1);
    wait_grant(4'b0100, 10, "post_rst_lowest");
    wait_drain(300, "post_rst_done");

    // Busy never rises: tx_start held, tx_data stable, no extra ready.
    uart_en = 1'b0;
    c = rdy_cnt[0];
    push_src(0, 8'h3C, 1'b1);
    wait_sig("start", 1'b1, 20);
    check("stuck_data", tx_data, 8'h3C);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("stuck_start", 32'(tx_start), 1);
      check("stuck_data_hold", tx_data, 8'h3C);
      check("stuck_no_ready", req_ready, 0);
    end
    check("stuck_ready_cnt", rdy_cnt[0], c + 1);
    check("final_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
